// File: rtl/testmode_pkg.sv
// Shared mode codes, FSM state type and default unlock key for testmode_enc.
package testmode_pkg;

  localparam logic [1:0] MODE_FUNC  = 2'b00;
  localparam logic [1:0] MODE_SCAN  = 2'b01;
  localparam logic [1:0] MODE_BIST  = 2'b10;
  localparam logic [1:0] MODE_ALIVE = 2'b11;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    EXIT  = 2'b01,
    APPLY = 2'b10
  } state_e;

  localparam logic [7:0] KEY_VAL_DEFAULT = 8'hA5;

endpackage

// File: rtl/testmode_settle_cnt.sv
// Loadable down-counter timing the EXIT and APPLY settle windows.
module testmode_settle_cnt #(
  parameter int unsigned CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [CNT_W-1:0] load_val,
  output logic [CNT_W-1:0] value,
  output logic             zero_c
);

  // Load wins over decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      value <= '0;
    end else if (load) begin
      value <= load_val;
    end else if (en) begin
      value <= value - CNT_W'(1);
    end
  end

  // Window end flag.
  assign zero_c = (value == '0);

endmodule

// File: rtl/testmode_enc.sv
// Test-mode code sequencer: every change of TEST passes through 00 for a
// settle window, then holds the new code for a second window before DONE.
// Optional unlock-key gating is enabled by defining TESTMODE_KEY_EN.
module testmode_enc
  import testmode_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 4,
  parameter int unsigned CNT_W      = 3
`ifdef TESTMODE_KEY_EN
  ,
  parameter logic [7:0]  KEY_VAL    = KEY_VAL_DEFAULT
`endif
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       REQ_VALID,
  input  logic [1:0] REQ_MODE,
  output logic       REQ_READY,
  input  logic       ABORT,
  output logic [1:0] TEST,
  output logic [1:0] MODE_CUR,
  output logic       BUSY,
  output logic       DONE
`ifdef TESTMODE_KEY_EN
  ,
  input  logic       KEY_VALID,
  input  logic [7:0] KEY,
  output logic       ERR
`endif
);

  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYC - 1);

  state_e           state;
  logic [1:0]       target;
  logic             accept;
  logic             blocked;
  logic             same;
  logic             start;
  logic             cnt_load;
  logic             cnt_en;
  logic             cnt_zero;
  logic [CNT_W-1:0] cnt_load_val;
  logic [CNT_W-1:0] cnt_value;

  // Handshake only in IDLE, and never while ABORT is asserted.
  assign REQ_READY = (state == IDLE) && !ABORT;
  assign BUSY      = (state != IDLE);
  assign accept    = REQ_VALID && REQ_READY;

`ifdef TESTMODE_KEY_EN
  logic unlocked;
  logic done_func;

  // Non-functional requests are refused while locked.
  assign blocked   = accept && (REQ_MODE != MODE_FUNC) && !unlocked;
  // Completion of any transition landing on functional mode re-locks.
  assign done_func = (same && (REQ_MODE == MODE_FUNC)) ||
                     ((state == EXIT) && cnt_zero && (target == MODE_FUNC));
`else
  assign blocked   = 1'b0;
`endif

  assign same  = accept && !blocked && (REQ_MODE == MODE_CUR);
  assign start = accept && !blocked && (REQ_MODE != MODE_CUR);

  // Counter is loaded on entry to EXIT and APPLY, cleared on ABORT.
  assign cnt_load     = ABORT || start ||
                        ((state == EXIT) && cnt_zero && (target != MODE_FUNC));
  assign cnt_load_val = ABORT ? '0 : SETTLE_LOAD;
  assign cnt_en       = (state != IDLE) && !cnt_zero;

  testmode_settle_cnt #(
    .CNT_W (CNT_W)
  ) u_settle_cnt (
    .clk      (CLK),
    .rst_n    (RESET),
    .load     (cnt_load),
    .en       (cnt_en),
    .load_val (cnt_load_val),
    .value    (cnt_value),
    .zero_c   (cnt_zero)
  );

  // Sequencer FSM with registered TEST/MODE_CUR/DONE.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      state    <= IDLE;
      target   <= MODE_FUNC;
      TEST     <= MODE_FUNC;
      MODE_CUR <= MODE_FUNC;
      DONE     <= 1'b0;
`ifdef TESTMODE_KEY_EN
      ERR      <= 1'b0;
      unlocked <= 1'b0;
`endif
    end else begin
      DONE <= 1'b0;
`ifdef TESTMODE_KEY_EN
      ERR  <= 1'b0;
      if (ABORT || done_func) begin
        unlocked <= 1'b0;
      end else if (KEY_VALID) begin
        unlocked <= (KEY == KEY_VAL);
      end
`endif
      if (ABORT) begin
        state    <= IDLE;
        target   <= MODE_FUNC;
        TEST     <= MODE_FUNC;
        MODE_CUR <= MODE_FUNC;
      end else begin
        case (state)
          IDLE: begin
`ifdef TESTMODE_KEY_EN
            if (blocked) begin
              ERR <= 1'b1;
            end
`endif
            if (same) begin
              DONE <= 1'b1;
            end else if (start) begin
              target <= REQ_MODE;
              TEST   <= MODE_FUNC;
              state  <= EXIT;
            end
          end
          EXIT: begin
            if (cnt_zero) begin
              if (target == MODE_FUNC) begin
                MODE_CUR <= MODE_FUNC;
                DONE     <= 1'b1;
                state    <= IDLE;
              end else begin
                TEST  <= target;
                state <= APPLY;
              end
            end
          end
          APPLY: begin
            if (cnt_zero) begin
              MODE_CUR <= target;
              DONE     <= 1'b1;
              state    <= IDLE;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_testmode_enc.sv
// Bench for testmode_enc: per-cycle scoreboard against a schedule-based
// model, plus directed cycle-exact checks. Define TESTMODE_KEY_EN for key tests.
module tb_testmode_enc;

  localparam int SETTLE = 4;
`ifdef TESTMODE_KEY_EN
  localparam bit KEY_EN = 1'b1;
`else
  localparam bit KEY_EN = 1'b0;
`endif

  logic       CLK = 1'b0;
  logic       RESET = 1'b0;
  logic       REQ_VALID = 1'b0;
  logic [1:0] REQ_MODE = 2'b00;
  logic       ABORT = 1'b0;
  logic       KEY_VALID = 1'b0;
  logic [7:0] KEY = 8'h00;
  logic       REQ_READY;
  logic [1:0] TEST;
  logic [1:0] MODE_CUR;
  logic       BUSY;
  logic       DONE;
  logic       ERR;

  int n_cmp = 0;
  int n_err = 0;

  testmode_enc #(
    .SETTLE_CYC (SETTLE),
    .CNT_W      (3)
  ) dut (
    .CLK       (CLK),
    .RESET     (RESET),
    .REQ_VALID (REQ_VALID),
    .REQ_MODE  (REQ_MODE),
    .REQ_READY (REQ_READY),
    .ABORT     (ABORT),
    .TEST      (TEST),
    .MODE_CUR  (MODE_CUR),
    .BUSY      (BUSY),
    .DONE      (DONE)
`ifdef TESTMODE_KEY_EN
    ,
    .KEY_VALID (KEY_VALID),
    .KEY       (KEY),
    .ERR       (ERR)
`endif
  );

`ifndef TESTMODE_KEY_EN
  assign ERR = 1'b0;
`endif

  always #5 CLK = ~CLK;

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: one expected output tuple per cycle; a transition is a precomputed
  // schedule of S cycles at 00, S cycles at the target (if non-00), then DONE.
  typedef struct packed {
    logic [1:0] t;
    logic [1:0] m;
    logic       b;
    logic       d;
  } mexp_t;

  mexp_t mq[$];
  mexp_t cur = '0;
  bit    cur_err = 1'b0;
  bit    unlocked = 1'b0;

  task automatic model_step();
    if (!RESET) begin
      mq.delete();
      cur      = '0;
      cur_err  = 1'b0;
      unlocked = 1'b0;
    end else begin
      cur_err = 1'b0;
      if (ABORT) begin
        mq.delete();
        cur      = '0;
        unlocked = 1'b0;
      end else begin
        if (mq.size() == 0) begin
          cur.d = 1'b0;
          if (REQ_VALID) begin
            if (KEY_EN && !unlocked && REQ_MODE != 2'b00) begin
              cur_err = 1'b1;
            end else if (REQ_MODE == cur.m) begin
              cur.d = 1'b1;
            end else begin
              for (int i = 0; i < SETTLE; i++) mq.push_back({2'b00, cur.m, 1'b1, 1'b0});
              if (REQ_MODE != 2'b00)
                for (int i = 0; i < SETTLE; i++) mq.push_back({REQ_MODE, cur.m, 1'b1, 1'b0});
              mq.push_back({REQ_MODE, REQ_MODE, 1'b0, 1'b1});
            end
          end
        end
        if (mq.size() > 0) cur = mq.pop_front();
        if (cur.d && cur.m == 2'b00) unlocked = 1'b0;
        else if (KEY_VALID) unlocked = (KEY == 8'hA5);
      end
    end
  endtask

  initial forever begin
    @(posedge CLK or negedge RESET);
    model_step();
  end

  // Scoreboard compare every cycle away from the active edge.
  initial forever begin
    @(negedge CLK);
    chk("sb_test", int'(TEST), int'(cur.t));
    chk("sb_mode_cur", int'(MODE_CUR), int'(cur.m));
    chk("sb_busy", int'(BUSY), int'(cur.b));
    chk("sb_done", int'(DONE), int'(cur.d));
    chk("sb_ready", int'(REQ_READY), int'(!cur.b && !ABORT));
    if (KEY_EN) chk("sb_err", int'(ERR), int'(cur_err));
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  // Hold a request until handshake; returns in cycle k+1.
  task automatic req(input logic [1:0] m);
    int i;
    REQ_VALID = 1'b1;
    REQ_MODE  = m;
    for (i = 0; i < 60; i++) begin
      @(negedge CLK);
      if (REQ_READY) break;
    end
    chk("req_ready_seen", int'(REQ_READY), 1);
    @(posedge CLK);
    #1;
    REQ_VALID = 1'b0;
  endtask

  task automatic wait_done(input int budget);
    for (int i = 0; i < budget; i++) begin
      if (DONE) break;
      step(1);
    end
    chk("done_seen", int'(DONE), 1);
  endtask

  initial begin
    automatic logic [1:0] sweep [5] = '{2'b11, 2'b10, 2'b00, 2'b11, 2'b00};

    // Reset values
    @(negedge CLK);
    chk("rst_test", int'(TEST), 0);
    chk("rst_mode", int'(MODE_CUR), 0);
    chk("rst_ready", int'(REQ_READY), 1);
    chk("rst_busy", int'(BUSY), 0);
    chk("rst_done", int'(DONE), 0);
    step(2);
    RESET = 1'b1;
    step(10);
    chk("idle_test", int'(TEST), 0);
    chk("idle_busy", int'(BUSY), 0);

    // 00 -> 10: TEST=00 cycles 1-4, 10 from cycle 5, DONE only cycle 9
    req(2'b10);
    for (int i = 1; i <= 9; i++) begin
      chk("seq10_test", int'(TEST), (i <= 4) ? 0 : 2);
      chk("seq10_done", int'(DONE), (i == 9) ? 1 : 0);
      if (i < 9) step(1);
    end
    chk("seq10_mode", int'(MODE_CUR), 2);

    // 10 -> 01 must pass through four cycles of 00
    step(1);
    req(2'b01);
    for (int i = 1; i <= 5; i++) begin
      chk("seq01_test", int'(TEST), (i <= 4) ? 0 : 1);
      if (i < 5) step(1);
    end
    wait_done(10);
    chk("seq01_mode", int'(MODE_CUR), 1);

    // 01 -> 00: DONE at k+5
    step(1);
    req(2'b00);
    for (int i = 1; i <= 5; i++) begin
      chk("seq00_test", int'(TEST), 0);
      chk("seq00_done", int'(DONE), (i == 5) ? 1 : 0);
      if (i < 5) step(1);
    end
    chk("seq00_mode", int'(MODE_CUR), 0);

    // ABORT during APPLY (cycle k+6), request held across ABORT
    step(1);
    req(2'b01);
    step(5);
    chk("abort_pre_test", int'(TEST), 1);
    ABORT     = 1'b1;
    REQ_VALID = 1'b1;
    REQ_MODE  = 2'b10;
    step(1);
    chk("abort_test", int'(TEST), 0);
    chk("abort_mode", int'(MODE_CUR), 0);
    chk("abort_done", int'(DONE), 0);
    chk("abort_ready", int'(REQ_READY), 0);
    step(1);
    ABORT     = 1'b0;
    REQ_VALID = 1'b0;
    chk("abort_no_accept", int'(BUSY), 0);
    step(2);

    // Same-mode request: DONE next cycle, no transition
    req(2'b00);
    chk("same_done", int'(DONE), 1);
    chk("same_busy", int'(BUSY), 0);
    chk("same_test", int'(TEST), 0);
    step(1);
    chk("same_done_clr", int'(DONE), 0);

    // REQ_VALID while busy gets no handshake
    req(2'b01);
    REQ_VALID = 1'b1;
    REQ_MODE  = 2'b11;
    step(3);
    chk("busy_ready", int'(REQ_READY), 0);
    REQ_VALID = 1'b0;
    wait_done(12);
    chk("busy_mode", int'(MODE_CUR), 1);
    step(3);
    chk("busy_no_extra", int'(BUSY), 0);
    chk("busy_mode_hold", int'(MODE_CUR), 1);

    // Sweep of transitions checked by the scoreboard
    foreach (sweep[i]) begin
      req(sweep[i]);
      wait_done(20);
      chk("sweep_mode", int'(MODE_CUR), int'(sweep[i]));
      step(1);
    end

`ifdef TESTMODE_KEY_EN
    // Locked: non-00 request refused with ERR
    req(2'b01);
    chk("lock_err", int'(ERR), 1);
    chk("lock_done", int'(DONE), 0);
    chk("lock_test", int'(TEST), 0);
    step(1);
    KEY_VALID = 1'b1;
    KEY       = 8'hA5;
    step(1);
    KEY_VALID = 1'b0;
    req(2'b01);
    chk("unlock_busy", int'(BUSY), 1);
    wait_done(12);
    chk("unlock_mode", int'(MODE_CUR), 1);
    step(1);
    req(2'b00);
    wait_done(12);
    step(1);
    req(2'b10);
    chk("relock_err", int'(ERR), 1);
    chk("relock_test", int'(TEST), 0);
    step(1);
`endif

    // Asynchronous reset mid-transition
    req(2'b11);
    step(2);
    RESET = 1'b0;
    #1;
    chk("midrst_test", int'(TEST), 0);
    chk("midrst_busy", int'(BUSY), 0);
    chk("midrst_mode", int'(MODE_CUR), 0);
    step(1);
    RESET = 1'b1;
    step(3);
    chk("postrst_ready", int'(REQ_READY), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected finish");
    $fatal(1);
  end

endmodule
